// File: rtl/laser_sweep_ctrl.sv
// Coverage-search sequencer: sweeps all 256 centers per round, feeding a shared
// evaluator one 5-point batch at a time, and alternates the two circles.
module laser_sweep_ctrl #(
  parameter int ITR_TIME = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic [3:0] cen_x,
  output logic [3:0] cen_y,
  output logic [2:0] batch_idx,
  output logic       eval_valid,
  input  logic       eval_ready,
  input  logic       hit_valid,
  input  logic [4:0] hit,
  output logic [3:0] c1x,
  output logic [3:0] c1y,
  output logic [3:0] c2x,
  output logic [3:0] c2y,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_SWAP,
    S_FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cand;
  logic [2:0]  k;
  logic [2:0]  round_cnt;
  logic [5:0]  best_sum;
  logic [39:0] cov;
  logic [39:0] c1_mask;
  logic [39:0] c2_mask;
  logic [7:0]  c1;
  logic [7:0]  c2;
  logic [39:0] uni;
  logic [5:0]  sum;
  logic        better;
  logic        last_cand;
  logic        last_round;

  assign uni = cov | c2_mask;

  // Coverage of the candidate combined with the fixed second circle.
  always_comb begin
    sum = 6'd0;
    for (int i = 0; i < 40; i++) begin
      sum = sum + {5'd0, uni[i]};
    end
  end

  assign better     = (sum >= best_sum);
  assign last_cand  = (cand == 8'hFF);
  assign last_round = (round_cnt == 3'(ITR_TIME));

  assign cen_x     = cand[3:0];
  assign cen_y     = cand[7:4];
  assign batch_idx = k;
  assign c1x       = c1[3:0];
  assign c1y       = c1[7:4];
  assign c2x       = c2[3:0];
  assign c2y       = c2[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    eval_valid = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        eval_valid = 1'b1;
        if (eval_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (hit_valid) state_nxt = (k == 3'd7) ? S_CMP : S_ISSUE;
      end
      S_CMP: begin
        if (!last_cand)      state_nxt = S_ISSUE;
        else if (last_round) state_nxt = S_FIN;
        else                 state_nxt = S_SWAP;
      end
      S_SWAP: begin
        state_nxt = S_ISSUE;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= 8'd0;
      k         <= 3'd0;
      round_cnt <= 3'd0;
      best_sum  <= 6'd0;
      cov       <= 40'd0;
      c1_mask   <= 40'd0;
      c2_mask   <= 40'd0;
      c1        <= 8'd0;
      c2        <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cand      <= 8'd0;
            k         <= 3'd0;
            round_cnt <= 3'd0;
            best_sum  <= 6'd0;
            cov       <= 40'd0;
            c1_mask   <= 40'd0;
            c2_mask   <= 40'd0;
            c1        <= 8'd0;
            c2        <= 8'd0;
          end
        end
        S_WAIT: begin
          if (hit_valid) begin
            for (int i = 0; i < 8; i++) begin
              if (k == 3'(i)) cov[5*i +: 5] <= hit;
            end
            if (k != 3'd7) k <= k + 3'd1;
          end
        end
        S_CMP: begin
          // Ties favour the later candidate in scan order.
          if (better) begin
            best_sum <= sum;
            c1       <= cand;
            c1_mask  <= cov;
          end
          k <= 3'd0;
          if (!last_cand) cand <= cand + 8'd1;
        end
        S_SWAP: begin
          // best_sum is kept: the union of the two circles is unchanged.
          c1        <= c2;
          c2        <= c1;
          c1_mask   <= c2_mask;
          c2_mask   <= c1_mask;
          round_cnt <= round_cnt + 3'd1;
          cand      <= 8'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_sweep_ctrl.sv
// Randomized bench for laser_sweep_ctrl: a behavioural evaluator with stalls and
// spurious strobes, checked against a whole-job coverage-search model.
module tb_laser_sweep_ctrl;

  localparam int ITR = 4;
  localparam int R2  = 16;
  localparam int BASE_CYCLES = 256 * (ITR + 1) * 17 + ITR + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic [3:0] cen_x;
  logic [3:0] cen_y;
  logic [2:0] batch_idx;
  logic       eval_valid;
  logic       eval_ready;
  logic       hit_valid;
  logic [4:0] hit;
  logic [3:0] c1x;
  logic [3:0] c1y;
  logic [3:0] c2x;
  logic [3:0] c2y;
  logic       done;

  int total;
  int bad;
  int px [40];
  int py [40];
  logic [39:0] cmask [256];
  int  stall_cnt;
  bit  stall_en;
  bit  spur_en;

  laser_sweep_ctrl #(.ITR_TIME(ITR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .cen_x(cen_x), .cen_y(cen_y), .batch_idx(batch_idx),
    .eval_valid(eval_valid), .eval_ready(eval_ready),
    .hit_valid(hit_valid), .hit(hit),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic bit inside_circle(int p, int x, int y);
    int dx;
    int dy;
    dx = px[p] - x;
    dy = py[p] - y;
    return (dx * dx + dy * dy) <= R2;
  endfunction

  task automatic setPoints(input int mode);
    for (int p = 0; p < 40; p++) begin
      case (mode)
        0: begin px[p] = 5; py[p] = 5; end
        1: begin
          px[p] = (p < 20) ? 2 : 12;
          py[p] = (p < 20) ? 2 : 12;
        end
        default: begin
          px[p] = int'($urandom_range(0, 15));
          py[p] = int'($urandom_range(0, 15));
        end
      endcase
    end
    for (int c = 0; c < 256; c++) begin
      for (int p = 0; p < 40; p++) cmask[c][p] = inside_circle(p, c % 16, c / 16);
    end
  endtask

  // Whole-job reference: greedy best first circle against the other, swapped ITR times.
  task automatic modelJob(output int e1, output int e2);
    int best;
    int s;
    int t;
    logic [39:0] m1;
    logic [39:0] m2;
    logic [39:0] tm;
    e1 = 0; e2 = 0; best = 0; m1 = '0; m2 = '0;
    for (int r = 0; r <= ITR; r++) begin
      for (int c = 0; c < 256; c++) begin
        s = $countones(cmask[c] | m2);
        if (s >= best) begin
          best = s; e1 = c; m1 = cmask[c];
        end
      end
      if (r < ITR) begin
        t = e1; e1 = e2; e2 = t;
        tm = m1; m1 = m2; m2 = tm;
      end
    end
  endtask

  function automatic int pickStall();
    if (!stall_en) return 0;
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Evaluator: one request at a time, optional ready/response stalls, optional junk strobes.
  initial begin : evaluator
    bit pending;
    bit armed;
    int rdelay;
    int hdelay;
    logic [3:0] lat_x;
    logic [3:0] lat_y;
    logic [2:0] lat_k;
    pending = 0; armed = 0; rdelay = 0; hdelay = 0;
    lat_x = '0; lat_y = '0; lat_k = '0;
    eval_ready = 1'b0; hit_valid = 1'b0; hit = '0;
    forever begin
      @(negedge clk);
      eval_ready = 1'b0;
      hit_valid  = 1'b0;
      hit        = '0;
      if (!rst_n) begin
        pending = 0;
        armed   = 0;
      end else if (pending) begin
        if (spur_en && $urandom_range(0, 3) == 0) eval_ready = 1'b1;
        if (hdelay > 0) begin
          hdelay--;
          stall_cnt++;
        end else begin
          hit_valid = 1'b1;
          for (int i = 0; i < 5; i++) hit[i] = inside_circle(5 * int'(lat_k) + i, int'(lat_x), int'(lat_y));
          pending = 0;
        end
      end else if (eval_valid) begin
        if (!armed) begin
          armed  = 1;
          rdelay = pickStall();
          lat_x  = cen_x;
          lat_y  = cen_y;
          lat_k  = batch_idx;
        end else begin
          checkOutput("req_hold", {cen_y, cen_x, batch_idx}, {lat_y, lat_x, lat_k});
        end
        if (spur_en && $urandom_range(0, 3) == 0) begin
          hit_valid = 1'b1;
          hit = 5'($urandom);
        end
        if (rdelay > 0) begin
          rdelay--;
          stall_cnt++;
        end else begin
          eval_ready = 1'b1;
          pending = 1;
          armed   = 0;
          hdelay  = pickStall();
        end
      end else if (spur_en) begin
        if ($urandom_range(0, 3) == 0) begin
          hit_valid = 1'b1;
          hit = 5'($urandom);
        end
        if ($urandom_range(0, 3) == 0) eval_ready = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int expect_union, input bit start_in_fin);
    int e1;
    int e2;
    int cyc;
    logic [3:0] h1x;
    logic [3:0] h1y;
    modelJob(e1, e2);
    @(negedge clk);
    stall_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checkOutput("busy_first", busy, 1);
    checkOutput("clear_c1c2", {c1x, c1y, c2x, c2y}, 0);
    while (!done && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      start = (spur_en && !done && $urandom_range(0, 63) == 0);
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1);
    checkOutput("done_cycle", cyc, BASE_CYCLES + stall_cnt);
    checkOutput("busy_at_done", busy, 1);
    checkOutput("c1", {c1y, c1x}, e1);
    checkOutput("c2", {c2y, c2x}, e2);
    if (expect_union > 0)
      checkOutput("pair_cov", $countones(cmask[{c1y, c1x}] | cmask[{c2y, c2x}]), expect_union);
    h1x = c1x;
    h1y = c1y;
    if (start_in_fin) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_pulse", done, 0);
    checkOutput("idle_after", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_hold", busy, 0);
    checkOutput("c1_hold", {c1y, c1x}, {h1y, h1x});
  endtask

  task automatic abortJob();
    int cyc;
    int done_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outs",
                {busy, done, eval_valid, cen_x, cen_y, batch_idx, c1x, c1y, c2x, c2y}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_nodone", done_seen, 0);
    checkOutput("abort_idle", busy, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    stall_cnt = 0;
    stall_en = 0;
    spur_en = 0;
    start = 1'b0;
    rst_n = 1'b0;
    setPoints(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outs",
                {busy, done, eval_valid, cen_x, cen_y, batch_idx, c1x, c1y, c2x, c2y}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_idle", busy, 0);

    $display("[TB] job 1: cluster at (5,5), zero-stall evaluator");
    applyStimulus(0, 1'b1);

    $display("[TB] job 2: split clusters, stalls and spurious inputs");
    setPoints(1);
    stall_en = 1;
    spur_en = 1;
    applyStimulus(40, 1'b0);

    $display("[TB] job 3: random points, reset mid-job then full rerun");
    setPoints(2);
    abortJob();
    applyStimulus(0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
